fnd_result_display: RTL
=======================

Name: fnd_result_display

Overview:
- Downstream consumer of the 4-bit adder/subtractor result.
- Captures {carry, sum} plus the mode bit on a load strobe and converts it to a signed decimal value (-16..+30).
- Drives a 4-digit common-anode FND with time-multiplexed scanning.
- Sits between the arithmetic datapath and the board's segment/common pins.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; legal minimum is 2.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_sum  input  4  o_sum from the adder/subtractor
- i_carry  input  1  o_carry from the adder/subtractor
- i_mode  input  1  0 = add result, 1 = subtract result (same i_mode that drives the adder)
- i_load  input  1  single-cycle capture strobe
- o_com  output  4  digit enables, active-low; bit0 = rightmost digit
- o_seg  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset, asserted asynchronously on i_reset_n low:
  - o_com = 4'b1111, o_seg = 8'hFF.
  - Scan counter = 0, digit index = 0.
  - Captured value = add mode, carry 0, sum 0.
- Capture: on a clock edge with i_load = 1, register {i_mode, i_carry, i_sum}. The new value is used from the next digit tick onward, so there is no tearing within a digit slot.
- Value decode (combinational from the capture register):
  - Add mode: magnitude = {carry,sum} (0..31), sign = positive.
  - Subtract mode, carry = 1: magnitude = sum (0..15), positive.
  - Subtract mode, carry = 0: negative, magnitude = 16 - sum. sum = 0 yields 16, shown as "-16".
  - Tens = magnitude / 10, ones = magnitude % 10. Tens is 0..3 and must not be computed with a generic divider; use compare/subtract.
- Digit content:
  - idx0: ones digit, always shown.
  - idx1: tens digit, blank if tens = 0.
  - idx2: blank.
  - idx3: '-' if negative, else blank.
- Segment codes:
  - Digits 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90 (hex).
  - Minus = BF, blank = FF.
  - dp is always off.
- Scan timing:
  - The scan counter counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (counter == SCAN_DIV-1).
  - On tick: o_com <= one-hot-low for the current idx (idx0 -> 4'b1110, idx3 -> 4'b0111), o_seg <= code for that digit, then idx <= idx+1 with wrap from 3 to 0.
  - The first tick occurs SCAN_DIV cycles after reset release. Outputs stay at reset values until then.
  - o_com and o_seg are registered and change on the same edge. Exactly one o_com bit is low after the first tick.
- Simultaneous events:
  - i_load on a tick cycle: the tick uses the old captured value; the new value applies from the following tick.
  - i_load held high: capture every cycle, last value wins.
- Reset mid-scan: immediate return to reset values; the scan restarts from idx0 after SCAN_DIV cycles.
- No combinational path from any input to any output.

Test Plan (SCAN_DIV = 4):
- Reset then idle 20 cycles -> o_com/o_seg = 1111/FF for the first 4 cycles. Then cycling 1110/C0, 1101/FF, 1011/FF, 0111/FF (shows "0"), one change every 4 cycles.
- Load add, sum = 4'h2, carry = 1 (9+9) -> per scan: idx0 = 80 ('8'), idx1 = F9 ('1'), idx2 = FF, idx3 = FF.
- Load sub, sum = 4'hE, carry = 0 (3-5) -> idx0 = A4 ('2'), idx1 = FF, idx2 = FF, idx3 = BF ('-').
- Load sub, sum = 0, carry = 0 -> "-16": idx0 = 82, idx1 = F9, idx3 = BF. Load add, sum = 4'hE, carry = 1 (15+15) -> idx0 = C0, idx1 = B0 ("30").
- Assert i_load on a tick cycle with a new value -> the current digit shows the old value; the next digit uses the new value.
- Pulse i_reset_n low mid-scan, asynchronous relative to i_clk -> outputs go to 1111/FF without waiting for an edge. Captured value clears to "0"; first digit appears 4 cycles after release, on idx0.

Source files
------------

// File: rtl/fnd_result_display.sv
`default_nettype none
// ============================================================================
// fnd_result_display : 4-bit adder/subtractor result to 4-digit common-anode FND
// Revision 1.0
// ============================================================================

module fnd_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_sum,
  input  logic       i_carry,
  input  logic       i_mode,
  input  logic       i_load,
  output logic [3:0] o_com,
  output logic [7:0] o_seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0] C_SEG_BLANK = 8'hFF;
  localparam logic [7:0] C_SEG_MINUS = 8'hBF;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [5:0]       cap_q, cap_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;

  logic       w_tick;
  logic       w_neg;
  logic [4:0] w_mag;
  logic [4:0] w_rem;
  logic [1:0] w_tens;
  logic [7:0] w_code;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = C_SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    w_tick = (cnt_q == C_CNT_MAX);
    cnt_d  = w_tick ? '0 : cnt_q + 1'b1;
    cap_d  = i_load ? {i_mode, i_carry, i_sum} : cap_q;

    // cap_q = {mode, carry, sum}
    w_neg = 1'b0;
    w_mag = cap_q[4:0];
    if (cap_q[5]) begin
      if (cap_q[4]) begin
        w_mag = {1'b0, cap_q[3:0]};
      end else begin
        w_neg = 1'b1;
        w_mag = 5'd16 - {1'b0, cap_q[3:0]};
      end
    end

    // Magnitude never exceeds 31, so three compares cover every tens value.
    if (w_mag >= 5'd30) begin
      w_tens = 2'd3;
      w_rem  = w_mag - 5'd30;
    end else if (w_mag >= 5'd20) begin
      w_tens = 2'd2;
      w_rem  = w_mag - 5'd20;
    end else if (w_mag >= 5'd10) begin
      w_tens = 2'd1;
      w_rem  = w_mag - 5'd10;
    end else begin
      w_tens = 2'd0;
      w_rem  = w_mag;
    end

    case (idx_q)
      2'd0:    w_code = seg_of(w_rem[3:0]);
      2'd1:    w_code = (w_tens == 2'd0) ? C_SEG_BLANK : seg_of({2'b00, w_tens});
      2'd2:    w_code = C_SEG_BLANK;
      default: w_code = w_neg ? C_SEG_MINUS : C_SEG_BLANK;
    endcase

    com_d = com_q;
    seg_d = seg_q;
    idx_d = idx_q;
    if (w_tick) begin
      com_d = ~(4'b0001 << idx_q);
      seg_d = w_code;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      cap_q <= 6'd0;
      com_q <= 4'b1111;
      seg_q <= C_SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cap_q <= cap_d;
      com_q <= com_d;
      seg_q <= seg_d;
    end
  end

  assign o_com = com_q;
  assign o_seg = seg_q;

endmodule

`default_nettype wire
